logistic_iter: RTL and testbench

//  Iterates the logistic map x[n+1] = mu*x[n]*(1-x[n]) in unsigned Q2.16 fixed point, one step per rising

---
 rtl/chaos_pkg.sv | 22 ++
 rtl/logistic_iter_if.sv | 31 +++
 rtl/fx_mul_q2_16.sv | 20 ++
 rtl/logistic_iter.sv | 156 +++++++++++++++
 tb/tb_logistic_iter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/chaos_pkg.sv
// Shared Q2.16 fixed-point constants and the orbit FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chaos_pkg;

    // Q2.16: 2 integer bits, 16 fraction bits
    localparam int Q_W    = 18;
    localparam int Q_FRAC = 16;

    // 1.0 in Q2.16
    localparam logic [Q_W-1:0] ONE_Q = 18'h10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MUL1,
        S_MUL2,
        S_WB,
        S_DONE
    } state_t;

endpackage

// File: rtl/logistic_iter_if.sv
// Control/data bundle between sample_set, the logistic iterator and the display stage.
// Latency: n/a (wires only).
// Backpressure: none; x_valid is a fire-and-forget pulse with no ready.
interface logistic_iter_if #(
    parameter int W     = 18,
    parameter int CNT_W = 9
);
    logic             start;
    logic [W-1:0]     mu;
    logic [CNT_W-1:0] maxrepeat;
    logic [W-1:0]     x_seed;
    logic             calc_clock;
    logic [W-1:0]     x_out;
    logic             x_valid;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             done;
    logic             converged;

    // Driver side: sample_set / stimulus
    modport master (
        output start, mu, maxrepeat, x_seed, calc_clock,
        input  x_out, x_valid, iter_cnt, busy, done, converged
    );

    // Iterator side
    modport slave (
        input  start, mu, maxrepeat, x_seed, calc_clock,
        output x_out, x_valid, iter_cnt, busy, done, converged
    );
endinterface

// File: rtl/fx_mul_q2_16.sv
// Unsigned Q2.16 x Q2.16 multiply, truncated back to Q2.16 (bits [33:16] of the product).
// Latency: combinational.
// Backpressure: none.
module fx_mul_q2_16
    import chaos_pkg::*;
#(
    parameter int W = Q_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [2*W-1:0] prod;

    // Full-width product; bits above the Q2.16 window are dropped (zero for x<1, mu<4)
    assign prod = a * b;
    assign y    = W'(prod >> Q_FRAC);

endmodule

// File: rtl/logistic_iter.sv
// Logistic map x[n+1] = mu*x*(1-x) in Q2.16, one step per synchronized calc_clock rising edge.
// Latency: tick (post-sync) to x_valid = 4 CLK; calc_clock edge to x_valid about 6-7 CLK.
// Backpressure: none; ticks arriving outside WAIT are dropped. Optional: LOGISTIC_EARLY_STOP_EN.
module logistic_iter
    import chaos_pkg::*;
#(
    parameter int W     = Q_W,
    parameter int CNT_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    logistic_iter_if.slave    bus
);

    state_t           state;
    logic [W-1:0]     mu_q;
    logic [CNT_W-1:0] maxrep_q;
    logic [W-1:0]     x_q;
    logic [W-1:0]     p1_q;
    logic [W-1:0]     p2_q;
    logic [W-1:0]     x_out_q;
    logic             x_valid_q;
    logic [CNT_W-1:0] iter_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             conv_q;

    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             tick;

    logic [W-1:0]     one_minus_x;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [W-1:0]     mul_y;
    logic [CNT_W-1:0] cnt_next;
    logic             stop_early;

    // calc_clock is data from another domain: two-flop synchronizer plus edge history
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= bus.calc_clock;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign tick = sync2 & ~sync_prev;

    // 1 - x, clamped to zero so an x at or above 1.0 cannot wrap
    assign one_minus_x = (x_q >= ONE_Q) ? '0 : (ONE_Q - x_q);

    // One shared multiplier: x*(1-x) in MUL1, mu*p1 otherwise
    assign mul_a = (state == S_MUL1) ? x_q         : mu_q;
    assign mul_b = (state == S_MUL1) ? one_minus_x : p1_q;

    fx_mul_q2_16 #(.W(W)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    assign cnt_next = iter_cnt_q + CNT_W'(1);

`ifdef LOGISTIC_EARLY_STOP_EN
    assign stop_early = (p2_q == x_q);
`else
    assign stop_early = 1'b0;
`endif

    // Orbit sequencer; start is accepted in every state and always wins over a pending write-back
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            mu_q       <= '0;
            maxrep_q   <= '0;
            x_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            x_out_q    <= '0;
            x_valid_q  <= 1'b0;
            iter_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
        end else begin
            x_valid_q <= 1'b0;
            if (bus.start) begin
                mu_q       <= bus.mu;
                maxrep_q   <= bus.maxrepeat;
                x_q        <= bus.x_seed;
                iter_cnt_q <= '0;
                conv_q     <= 1'b0;
                if (bus.maxrepeat == '0) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state  <= S_WAIT;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end
            end else begin
                case (state)
                    S_WAIT: begin
                        if (tick) begin
                            state <= S_MUL1;
                        end
                    end
                    S_MUL1: begin
                        p1_q  <= mul_y;
                        state <= S_MUL2;
                    end
                    S_MUL2: begin
                        p2_q  <= mul_y;
                        state <= S_WB;
                    end
                    S_WB: begin
                        x_q        <= p2_q;
                        x_out_q    <= p2_q;
                        x_valid_q  <= 1'b1;
                        iter_cnt_q <= cnt_next;
                        if ((cnt_next == maxrep_q) || stop_early) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            conv_q <= stop_early;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign bus.x_out    = x_out_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.iter_cnt = iter_cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef LOGISTIC_EARLY_STOP_EN
    assign bus.converged = conv_q;
`else
    assign bus.converged = 1'b0;
`endif

endmodule

// File: tb/tb_logistic_iter.sv
// Directed plus randomized bench for logistic_iter against an arithmetic orbit model.
// Latency: n/a.
// Backpressure: n/a.
module tb_logistic_iter;
    import chaos_pkg::*;

    logic CLK;
    logic RST;

    logistic_iter_if #(.W(18), .CNT_W(9)) bus ();

    logistic_iter #(.W(18), .CNT_W(9)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [17:0] vq [$];
    logic [17:0] exp_q [$];
    logic        exp_conv;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every emitted iterate
    always @(negedge CLK) begin
        if (bus.x_valid === 1'b1) vq.push_back(bus.x_out);
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Orbit from the map definition with plain integer arithmetic
    task automatic build_exp(input longint unsigned mu, input longint unsigned seed, input int mr);
        longint unsigned x, omx, p1, p2;
        exp_q.delete();
        exp_conv = 1'b0;
        x = seed;
        for (int n = 0; n < mr; n++) begin
            omx = (x >= 65536) ? 0 : 65536 - x;
            p1  = ((x * omx) >> 16) & 'h3FFFF;
            p2  = ((mu * p1) >> 16) & 'h3FFFF;
            exp_q.push_back(p2[17:0]);
`ifdef LOGISTIC_EARLY_STOP_EN
            if (p2 == x) begin
                exp_conv = 1'b1;
                break;
            end
`endif
            x = p2;
        end
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic calc_edges(input int n);
        for (int i = 0; i < n; i++) begin
            bus.calc_clock = 1'b1;
            repeat (8) @(negedge CLK);
            bus.calc_clock = 1'b0;
            repeat (8) @(negedge CLK);
        end
    endtask

    task automatic run_orbit(input string tag, input logic [17:0] mu, input logic [17:0] seed,
                             input logic [8:0] mr, input int edges);
        bus.mu        = mu;
        bus.x_seed    = seed;
        bus.maxrepeat = mr;
        vq.delete();
        pulse_start();
        calc_edges(edges);
        build_exp(longint'(mu), longint'(seed), int'(mr));
        chk({tag, "_count"}, 36'(vq.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < vq.size(); i++)
            chk($sformatf("%s_x%0d", tag, i + 1), 36'(vq[i]), 36'(exp_q[i]));
        chk({tag, "_iter_cnt"}, 36'(bus.iter_cnt), 36'(exp_q.size()));
        chk({tag, "_done"}, 36'(bus.done), 36'd1);
        chk({tag, "_busy"}, 36'(bus.busy), 36'd0);
        chk({tag, "_converged"}, 36'(bus.converged), 36'(exp_conv));
    endtask

    initial begin
        int k;
        RST            = 1'b1;
        bus.start      = 1'b0;
        bus.mu         = '0;
        bus.maxrepeat  = '0;
        bus.x_seed     = '0;
        bus.calc_clock = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_x_out", 36'(bus.x_out), 36'd0);
        chk("rst_x_valid", 36'(bus.x_valid), 36'd0);
        chk("rst_iter_cnt", 36'(bus.iter_cnt), 36'd0);
        chk("rst_busy", 36'(bus.busy), 36'd0);
        chk("rst_done", 36'(bus.done), 36'd0);
        chk("rst_converged", 36'(bus.converged), 36'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 1: single step from 0.5
        bus.mu = 18'h2DBDF; bus.x_seed = 18'h08000; bus.maxrepeat = 9'd1;
        vq.delete();
        pulse_start();
        chk("t1_busy_after_start", 36'(bus.busy), 36'd1);
        calc_edges(1);
        chk("t1_count", 36'(vq.size()), 36'd1);
        chk("t1_x_out", 36'(bus.x_out), 36'h0B6F7);
        chk("t1_iter_cnt", 36'(bus.iter_cnt), 36'd1);
        chk("t1_done", 36'(bus.done), 36'd1);
        chk("t1_busy", 36'(bus.busy), 36'd0);

        // 2: three iterations, surplus ticks ignored
        run_orbit("t2", 18'h2DBDF, 18'h08000, 9'd3, 5);

        // 3: zero-length orbit
        bus.maxrepeat = 9'd0;
        vq.delete();
        pulse_start();
        chk("t3_done", 36'(bus.done), 36'd1);
        chk("t3_busy", 36'(bus.busy), 36'd0);
        chk("t3_iter_cnt", 36'(bus.iter_cnt), 36'd0);
        calc_edges(1);
        chk("t3_no_valid", 36'(vq.size()), 36'd0);

        // 4: fixed point at zero
        run_orbit("t4", 18'h2DBDF, 18'h00000, 9'd4, 5);
`ifdef LOGISTIC_EARLY_STOP_EN
        chk("t4_conv_const", 36'(bus.converged), 36'd1);
        chk("t4_cnt_const", 36'(bus.iter_cnt), 36'd1);
`else
        chk("t4_conv_const", 36'(bus.converged), 36'd0);
        chk("t4_cnt_const", 36'(bus.iter_cnt), 36'd4);
`endif

        // 5: restart mid-orbit
        bus.mu = 18'h3DBDF; bus.x_seed = 18'h04000; bus.maxrepeat = 9'd5;
        pulse_start();
        calc_edges(2);
        chk("t5_mid_iter_cnt", 36'(bus.iter_cnt), 36'd2);
        chk("t5_mid_busy", 36'(bus.busy), 36'd1);
        bus.x_seed = 18'h08000;
        bus.mu     = 18'h3DBDF;
        vq.delete();
        pulse_start();
        chk("t5_restart_iter_cnt", 36'(bus.iter_cnt), 36'd0);
        bus.mu = 18'h11111;  // ignored: latched at start
        calc_edges(1);
        chk("t5_count", 36'(vq.size()), 36'd1);
        chk("t5_x_out", 36'(bus.x_out), 36'h0F6F7);
        chk("t5_iter_cnt", 36'(bus.iter_cnt), 36'd1);

        // 6: reset in the middle of a step
        bus.mu = 18'h2DBDF; bus.x_seed = 18'h08000; bus.maxrepeat = 9'd4;
        pulse_start();
        bus.calc_clock = 1'b1;
        k = 0;
        while (k < 20 && dut.state != S_MUL2) begin
            @(negedge CLK);
            k++;
        end
        chk("t6_reach_mul2", 36'(k < 20), 36'd1);
        RST = 1'b1;
        #1;
        chk("t6_x_out", 36'(bus.x_out), 36'd0);
        chk("t6_x_valid", 36'(bus.x_valid), 36'd0);
        chk("t6_iter_cnt", 36'(bus.iter_cnt), 36'd0);
        chk("t6_busy", 36'(bus.busy), 36'd0);
        chk("t6_done", 36'(bus.done), 36'd0);
        chk("t6_converged", 36'(bus.converged), 36'd0);
        @(negedge CLK);
        bus.calc_clock = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        vq.delete();
        calc_edges(2);
        chk("t6_no_valid_after", 36'(vq.size()), 36'd0);
        chk("t6_busy_after", 36'(bus.busy), 36'd0);

        // Randomized orbits
        for (int r = 0; r < 8; r++) begin
            logic [17:0] rmu, rseed;
            logic [8:0]  rmr;
            rmu   = 18'($urandom_range(0, 18'h3FFFF));
            rseed = 18'($urandom_range(0, 16'hFFFF));
            rmr   = 9'($urandom_range(1, 6));
            run_orbit($sformatf("rnd%0d", r), rmu, rseed, rmr, int'(rmr) + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait above never completes
    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
